// File: rtl/counter_bank_pkg.sv
// Shared types and helpers for the counter bank: arithmetic mode, packed-slice
// indexing and width-generic constant values.
package counter_bank_pkg;

  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  function automatic mode_e mode_from_param(input int saturate);
    return (saturate != 0) ? MODE_SAT : MODE_WRAP;
  endfunction

  // Low bit of element idx in a vector of elements elem_w bits wide.
  function automatic int slice_lo(input int idx, input int elem_w);
    return idx * elem_w;
  endfunction

  // All-ones of the given width, valid up to 64 bits.
  function automatic logic [63:0] lp_max(input int width);
    return ~(64'hFFFF_FFFF_FFFF_FFFF << width);
  endfunction

  function automatic logic [63:0] lp_zero(input int width);
    return 64'd0 & lp_max(width);
  endfunction

endpackage

// File: rtl/counter_lane.sv
// One up/down counter channel with wrap/saturate arithmetic, limit compare
// and sticky overflow/underflow flags.
module counter_lane
  import counter_bank_pkg::*;
#(
  parameter int                   C_WIDTH    = 16,
  parameter int                   C_STEP_W   = 4,
  parameter logic [C_WIDTH-1:0]   C_INIT     = '0,
  parameter int                   C_SATURATE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clken,
  input  logic                load,
  input  logic                incr,
  input  logic                decr,
  input  logic [C_STEP_W-1:0] step,
  input  logic [C_WIDTH-1:0]  load_value,
  input  logic [C_WIDTH-1:0]  limit,
  input  logic                clr_sticky,
  output logic [C_WIDTH-1:0]  count,
  output logic                is_zero,
  output logic                at_limit,
  output logic                ovf,
  output logic                unf
);

  localparam mode_e              LP_MODE = mode_from_param(C_SATURATE);
  localparam logic [C_WIDTH-1:0] LP_MAX  = C_WIDTH'(lp_max(C_WIDTH));
  localparam logic [C_WIDTH-1:0] LP_ZERO = C_WIDTH'(lp_zero(C_WIDTH));

  logic [C_WIDTH-1:0] count_reg, count_next;
  logic               is_zero_reg, is_zero_next;
  logic               at_limit_reg, at_limit_next;
  logic               ovf_reg, ovf_next;
  logic               unf_reg, unf_next;

  logic [C_WIDTH:0]   step_ext;
  logic [C_WIDTH:0]   arith_ext;
  logic               ovf_set;
  logic               unf_set;

  assign step_ext = (C_WIDTH+1)'(step);

  // The extra MSB of arith_ext carries the carry (incr) or borrow (decr).
  always_comb begin
    count_next = count_reg;
    arith_ext  = '0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (load) begin
      count_next = load_value;
    end else if (incr && !decr) begin
      arith_ext = {1'b0, count_reg} + step_ext;
      ovf_set   = arith_ext[C_WIDTH];
      if (ovf_set && (LP_MODE == MODE_SAT)) begin
        count_next = LP_MAX;
      end else begin
        count_next = arith_ext[C_WIDTH-1:0];
      end
    end else if (decr && !incr) begin
      arith_ext = {1'b0, count_reg} - step_ext;
      unf_set   = arith_ext[C_WIDTH];
      if (unf_set && (LP_MODE == MODE_SAT)) begin
        count_next = LP_ZERO;
      end else begin
        count_next = arith_ext[C_WIDTH-1:0];
      end
    end
  end

  // Status is derived from the next count so it lands together with count.
  always_comb begin
    is_zero_next  = (count_next == LP_ZERO);
    at_limit_next = (count_next == limit);
    ovf_next      = ovf_set | (ovf_reg & ~clr_sticky);
    unf_next      = unf_set | (unf_reg & ~clr_sticky);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= C_INIT;
      is_zero_reg  <= (C_INIT == LP_ZERO);
      at_limit_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      unf_reg      <= 1'b0;
    end else if (clken) begin
      count_reg    <= count_next;
      is_zero_reg  <= is_zero_next;
      at_limit_reg <= at_limit_next;
      ovf_reg      <= ovf_next;
      unf_reg      <= unf_next;
    end
  end

  assign count    = count_reg;
  assign is_zero  = is_zero_reg;
  assign at_limit = at_limit_reg;
  assign ovf      = ovf_reg;
  assign unf      = unf_reg;

endmodule

// File: rtl/counter_bank.sv
// Bank of independent up/down counters sharing clock, reset, enable and limit.
// This level only slices the packed buses and reduces is_zero.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int                 C_NUM_CH   = 4,
  parameter int                 C_WIDTH    = 16,
  parameter int                 C_STEP_W   = 4,
  parameter logic [C_WIDTH-1:0] C_INIT     = '0,
  parameter int                 C_SATURATE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clken,
  input  logic [C_NUM_CH-1:0]          load,
  input  logic [C_NUM_CH-1:0]          incr,
  input  logic [C_NUM_CH-1:0]          decr,
  input  logic [C_NUM_CH*C_STEP_W-1:0] step,
  input  logic [C_NUM_CH*C_WIDTH-1:0]  load_value,
  input  logic [C_WIDTH-1:0]           limit,
  input  logic [C_NUM_CH-1:0]          clr_sticky,
  output logic [C_NUM_CH*C_WIDTH-1:0]  count,
  output logic [C_NUM_CH-1:0]          is_zero,
  output logic [C_NUM_CH-1:0]          at_limit,
  output logic [C_NUM_CH-1:0]          ovf,
  output logic [C_NUM_CH-1:0]          unf,
  output logic                         any_zero
);

  generate
    for (genvar gi = 0; gi < C_NUM_CH; gi++) begin : g_lane
      counter_lane #(
        .C_WIDTH    (C_WIDTH),
        .C_STEP_W   (C_STEP_W),
        .C_INIT     (C_INIT),
        .C_SATURATE (C_SATURATE)
      ) u_lane (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .load       (load[gi]),
        .incr       (incr[gi]),
        .decr       (decr[gi]),
        .step       (step[slice_lo(gi, C_STEP_W) +: C_STEP_W]),
        .load_value (load_value[slice_lo(gi, C_WIDTH) +: C_WIDTH]),
        .limit      (limit),
        .clr_sticky (clr_sticky[gi]),
        .count      (count[slice_lo(gi, C_WIDTH) +: C_WIDTH]),
        .is_zero    (is_zero[gi]),
        .at_limit   (at_limit[gi]),
        .ovf        (ovf[gi]),
        .unf        (unf[gi])
      );
    end
  endgenerate

  assign any_zero = |is_zero;

endmodule

// File: tb/tb_counter_bank.sv
// Directed table-driven bench: a 4-bit wrap bank and a 4-bit saturate bank,
// both with C_INIT=5, driven by the same stimulus.
module tb_counter_bank;

  localparam int NCH = 4;
  localparam int W   = 4;
  localparam int SW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, clken;
  logic [NCH-1:0]     load, incr, decr, clr_sticky;
  logic [NCH*SW-1:0]  step;
  logic [NCH*W-1:0]   load_value;
  logic [W-1:0]       limit;

  logic [NCH*W-1:0]   count_w, count_s;
  logic [NCH-1:0]     zero_w, zero_s, lim_w, lim_s, ovf_w, ovf_s, unf_w, unf_s;
  logic               anyz_w, anyz_s;

  counter_bank #(.C_NUM_CH(NCH), .C_WIDTH(W), .C_STEP_W(SW), .C_INIT(4'd5), .C_SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
    .step(step), .load_value(load_value), .limit(limit), .clr_sticky(clr_sticky),
    .count(count_w), .is_zero(zero_w), .at_limit(lim_w), .ovf(ovf_w), .unf(unf_w),
    .any_zero(anyz_w)
  );

  counter_bank #(.C_NUM_CH(NCH), .C_WIDTH(W), .C_STEP_W(SW), .C_INIT(4'd5), .C_SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .clken(clken), .load(load), .incr(incr), .decr(decr),
    .step(step), .load_value(load_value), .limit(limit), .clr_sticky(clr_sticky),
    .count(count_s), .is_zero(zero_s), .at_limit(lim_s), .ovf(ovf_s), .unf(unf_s),
    .any_zero(anyz_s)
  );

  typedef struct {
    logic       rst, clken, ld, inc, dec, clr;
    logic [3:0] stp, lv, lim;
    logic [3:0] cw;  logic ow, uw, zw, lw;
    logic [3:0] cs;  logic os, us, zs, ls;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;

  function automatic vec_t mk(input int r, ce, ld, inc, dec, clr, stp, lv, lim,
                              cw, ow, uw, zw, lw, cs, os, us, zs, ls);
    vec_t v;
    v.rst = r[0]; v.clken = ce[0]; v.ld = ld[0]; v.inc = inc[0]; v.dec = dec[0]; v.clr = clr[0];
    v.stp = stp[3:0]; v.lv = lv[3:0]; v.lim = lim[3:0];
    v.cw = cw[3:0]; v.ow = ow[0]; v.uw = uw[0]; v.zw = zw[0]; v.lw = lw[0];
    v.cs = cs[3:0]; v.os = os[0]; v.us = us[0]; v.zs = zs[0]; v.ls = ls[0];
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  vec_t vecs[22];

  initial begin
    //            rst ce ld in de cl stp lv lim | cw ow uw zw lw | cs os us zs ls
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0,  0,  0,   5, 0, 0, 0, 0,   5, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 0, 0, 0,  0,  5,   5, 0, 0, 0, 1,   5, 0, 0, 0, 1);
    vecs[2]  = mk(0, 1, 1, 0, 0, 0, 0, 14,  9,  14, 0, 0, 0, 0,  14, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 1, 0, 0, 3,  0,  9,   1, 1, 0, 0, 0,  15, 1, 0, 0, 0);
    vecs[4]  = mk(0, 1, 0, 0, 1, 0, 1,  0,  9,   0, 1, 0, 1, 0,  14, 1, 0, 0, 0);
    vecs[5]  = mk(0, 1, 1, 0, 0, 1, 0,  2,  9,   2, 0, 0, 0, 0,   2, 0, 0, 0, 0);
    vecs[6]  = mk(0, 1, 0, 0, 1, 0, 5,  0,  9,  13, 0, 1, 0, 0,   0, 0, 1, 1, 0);
    vecs[7]  = mk(0, 1, 0, 1, 0, 0, 15, 0,  9,  12, 1, 1, 0, 0,  15, 0, 1, 0, 0);
    vecs[8]  = mk(0, 1, 0, 1, 0, 0, 15, 0, 15,  11, 1, 1, 0, 0,  15, 1, 1, 0, 1);
    vecs[9]  = mk(0, 1, 0, 1, 1, 0, 3,  0, 11,  11, 1, 1, 0, 1,  15, 1, 1, 0, 0);
    vecs[10] = mk(0, 1, 0, 0, 0, 1, 0,  0, 11,  11, 0, 0, 0, 1,  15, 0, 0, 0, 0);
    vecs[11] = mk(0, 1, 1, 1, 0, 0, 1,  7,  9,   7, 0, 0, 0, 0,   7, 0, 0, 0, 0);
    vecs[12] = mk(0, 1, 0, 1, 0, 0, 0,  0,  9,   7, 0, 0, 0, 0,   7, 0, 0, 0, 0);
    vecs[13] = mk(0, 1, 1, 0, 0, 0, 0, 15,  9,  15, 0, 0, 0, 0,  15, 0, 0, 0, 0);
    vecs[14] = mk(0, 1, 0, 1, 0, 1, 1,  0,  9,   0, 1, 0, 1, 0,  15, 1, 0, 0, 0);
    vecs[15] = mk(0, 1, 0, 0, 0, 1, 0,  0,  9,   0, 0, 0, 1, 0,  15, 0, 0, 0, 0);
    vecs[16] = mk(0, 1, 0, 1, 0, 0, 15, 0,  9,  15, 0, 0, 0, 0,  15, 1, 0, 0, 0);
    vecs[17] = mk(0, 1, 0, 1, 0, 0, 1,  0,  9,   0, 1, 0, 1, 0,  15, 1, 0, 0, 0);
    vecs[18] = mk(0, 0, 1, 1, 0, 1, 2,  3,  0,   0, 1, 0, 1, 0,  15, 1, 0, 0, 0);
    vecs[19] = mk(0, 0, 1, 1, 0, 1, 2,  3,  0,   0, 1, 0, 1, 0,  15, 1, 0, 0, 0);
    vecs[20] = mk(0, 0, 1, 1, 0, 1, 2,  3,  0,   0, 1, 0, 1, 0,  15, 1, 0, 0, 0);
    vecs[21] = mk(1, 0, 0, 0, 0, 0, 0,  0,  9,   5, 0, 0, 0, 0,   5, 0, 0, 0, 0);

    rst = 1'b1; clken = 1'b0; load = '0; incr = '0; decr = '0; clr_sticky = '0;
    step = '0; load_value = '0; limit = '0;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst           = vecs[i].rst;
      clken         = vecs[i].clken;
      load          = {3'b000, vecs[i].ld};
      incr          = {3'b000, vecs[i].inc};
      decr          = {3'b000, vecs[i].dec};
      clr_sticky    = {3'b000, vecs[i].clr};
      step          = {12'h000, vecs[i].stp};
      load_value    = {12'h000, vecs[i].lv};
      limit         = vecs[i].lim;
      @(posedge clk);
      #1;
      chk("wrap_count",   i, 32'(count_w[3:0]), 32'(vecs[i].cw));
      chk("wrap_ovf",     i, 32'(ovf_w[0]),     32'(vecs[i].ow));
      chk("wrap_unf",     i, 32'(unf_w[0]),     32'(vecs[i].uw));
      chk("wrap_is_zero", i, 32'(zero_w[0]),    32'(vecs[i].zw));
      chk("wrap_at_lim",  i, 32'(lim_w[0]),     32'(vecs[i].lw));
      chk("wrap_anyzero", i, 32'(anyz_w),       32'(vecs[i].zw));
      chk("sat_count",    i, 32'(count_s[3:0]), 32'(vecs[i].cs));
      chk("sat_ovf",      i, 32'(ovf_s[0]),     32'(vecs[i].os));
      chk("sat_unf",      i, 32'(unf_s[0]),     32'(vecs[i].us));
      chk("sat_is_zero",  i, 32'(zero_s[0]),    32'(vecs[i].zs));
      chk("sat_at_lim",   i, 32'(lim_s[0]),     32'(vecs[i].ls));
      chk("sat_anyzero",  i, 32'(anyz_s),       32'(vecs[i].zs));
      $display("vec %0d: wrap cnt=%0d ovf=%0b unf=%0b | sat cnt=%0d ovf=%0b unf=%0b",
               i, count_w[3:0], ovf_w[0], unf_w[0], count_s[3:0], ovf_s[0], unf_s[0]);
    end

    // All channels loaded to 10, then stepped by 1,2,3,4 in the same cycle.
    @(negedge clk);
    rst = 1'b0; clken = 1'b1; load = 4'hF; incr = '0; decr = '0; clr_sticky = '0;
    load_value = 16'hAAAA; step = '0; limit = 4'd12;
    @(posedge clk); #1;
    chk("all_load_wrap", 100, 32'(count_w), 32'h0000_AAAA);
    chk("all_load_sat",  100, 32'(count_s), 32'h0000_AAAA);
    $display("multi load: wrap=%04h sat=%04h", count_w, count_s);

    @(negedge clk);
    load = '0; incr = 4'hF; step = 16'h4321;
    @(posedge clk); #1;
    chk("all_incr_wrap",  101, 32'(count_w), 32'h0000_EDCB);
    chk("all_incr_sat",   101, 32'(count_s), 32'h0000_EDCB);
    chk("all_limit_wrap", 101, 32'(lim_w),   32'h0000_0002);
    chk("all_zero_wrap",  101, 32'(zero_w),  32'h0000_0000);
    chk("all_ovf_wrap",   101, 32'(ovf_w),   32'h0000_0000);
    $display("multi incr: wrap=%04h sat=%04h at_limit=%04b", count_w, count_s, lim_w);

    // Reset in the middle of ongoing activity returns everything in one cycle.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_wrap", 102, 32'(count_w), 32'h0000_5555);
    chk("midrst_sat",  102, 32'(count_s), 32'h0000_5555);
    chk("midrst_lim",  102, 32'(lim_w),   32'h0000_0000);
    $display("mid reset: wrap=%04h sat=%04h", count_w, count_s);

    @(negedge clk);
    rst = 1'b0; incr = '0; clken = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
